mod_counter_ctrl: RTL and testbench
===================================

# mod_counter_ctrl

Programmable modulo up/down counter with a start/stop control FSM and lap counting. It is the next-state stage that drives the counter's storage bank: it computes and registers the count word and raises wrap/done status for downstream logic. One instance per counter channel; all outputs are registered.

## Interface
Parameters:
- WIDTH, 8, count/modulus/load width (>= 2)
- LAPW, 4, lap-count width

Ports:
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- start  input  1  begin a run (honoured in IDLE only)
- stop  input  1  abort a run (honoured in RUN only)
- en  input  1  advance enable, RUN only
- up  input  1  direction: 1 = increment, 0 = decrement (sampled every cycle)
- modulus  input  WIDTH  period, captured at start; 0 means 2^WIDTH
- load_val  input  WIDTH  initial count, captured at start
- laps  input  LAPW  wraps before done, captured at start; 0 = run until stop
- count  output  WIDTH  registered count value
- busy  output  1  high while state != IDLE
- wrap  output  1  one-cycle pulse, coincident with the wrapped count value
- done  output  1  one-cycle pulse on run completion

## Operation
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, count=0, busy=0, wrap=0, done=0, internal mod_r=0, lap_r=0. Reset overrides all other inputs.
- IDLE: count holds. On start=1, capture mod_r=modulus, lap_r=laps, and load count:
  - load_val, if modulus==0 or load_val < modulus;
  - otherwise 0.
  - Go to RUN. stop is ignored in IDLE.
- RUN: start ignored. Per cycle, by priority:
  - stop=1: go to IDLE; count holds; no wrap, no done.
  - else en=0: hold.
  - else up=1: count == last (mod_r-1, or all-ones if mod_r==0) gives count=0 and wrap=1; otherwise count+1.
  - else up=0: count == 0 gives count=last and wrap=1; otherwise count-1.
- On a wrap with lap_r != 0, decrement lap_r. If it reaches 0 on that wrap, go to DONE. With lap_r==0 captured at start (free-run), wraps never end the run.
- DONE: done=1 for exactly this cycle; count holds the wrapped value; start and stop ignored; go to IDLE next cycle.
- Arithmetic is modulo 2^WIDTH internally. No count value ≥ mod_r is ever produced when mod_r != 0.
- modulus==1: every enabled RUN cycle wraps, and count stays 0.

## Timing
- start sampled at edge k: count=load value and busy=1 after edge k. The first possible advance is at edge k+1.
- Each advance: 1-cycle latency from the en/up sample to the count update.
- wrap is high in the same cycle the wrapped count is visible.
- done follows the final wrap by exactly 1 cycle. busy drops one cycle after done.
- stop at edge j: busy=0 after edge j. A wrap that would have occurred at j is suppressed.
- Reset asserted mid-run: all outputs take their reset values after that edge. No done is emitted.
- Back-to-back runs: start is accepted in the first IDLE cycle after DONE, so the minimum gap is 1 idle cycle between done and the next busy.

## Structure
- Shared package counter_pkg:
  - state enum cnt_state_t {IDLE, RUN, DONE};
  - localparam helpers for the terminal-value computation (modulus 0 maps to all-ones).
- Sub-module mod_step: combinational next-value/wrap calculator. Inputs are count, mod_r and up; outputs are next count and wrap_next.
- The top level holds the FSM, the captured registers and the lap counter.

## Test plan
- Reset then idle:
  - hold reset 2 cycles, then start with modulus=5, load_val=3, laps=1, up=1, en=1.
  - Required: count 3,4,0 (wrap=1 on 0), done=1 the next cycle, busy=0 after that.
- Down count, modulus 0:
  - WIDTH=8, load_val=1, up=0, laps=2.
  - Required: count 1,0,255 (wrap), then 254..0, then 255 (wrap 2), then done.
- Out-of-range load and en gating:
  - modulus=4, load_val=9: count loads 0.
  - toggle en 1,0,1: count 0,1,1,2.
- Stop mid-run:
  - stop asserted in the cycle count=3 would wrap.
  - Required: no wrap, no done, busy=0 next cycle, count stays 3.
- Free-run:
  - laps=0, modulus=3, 10 enabled cycles.
  - Required: wrap pulses every 3rd cycle, done never asserts.
  - start during RUN is ignored and does not reload count.
- Reset mid-run:
  - assert reset while count=2 in RUN.
  - Required: count=0, busy=0, wrap=0, done=0 after that edge; a subsequent start loads normally.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and terminal-value helper for the modulo counter channel.
// Pure declarations: no latency, no flow control.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cnt_state_t;

  // Widest count supported by the terminal-value helper.
  localparam int MAX_W = 64;

  // Highest legal count for a period m; a period of 0 stands for 2^w.
  function automatic logic [MAX_W-1:0] term_value(input logic [MAX_W-1:0] m,
                                                  input int unsigned      w);
    logic [MAX_W-1:0] ones;
    ones = {MAX_W{1'b1}} >> (MAX_W - w);
    return (m == '0) ? ones : (m - 64'd1);
  endfunction

endpackage

// File: rtl/mod_step.sv
// Combinational next-count / wrap calculator for one modulo step.
// Zero latency; no flow control, the caller decides whether to apply it.
module mod_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] mod_r,
  input  logic             up,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap_next
);

  logic [WIDTH-1:0] last;

  assign last = WIDTH'(term_value(MAX_W'(mod_r), WIDTH));

  always_comb begin
    count_next = count + WIDTH'(1);
    wrap_next  = 1'b0;
    if (up) begin
      if (count == last) begin
        count_next = '0;
        wrap_next  = 1'b1;
      end
    end else begin
      count_next = count - WIDTH'(1);
      if (count == '0) begin
        count_next = last;
        wrap_next  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_counter_ctrl.sv
// Modulo up/down counter with start/stop FSM and lap-limited runs; all outputs registered.
// One-cycle latency from start/en/up to count; no backpressure, done is a single-cycle pulse.
module mod_counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAPW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] load_val,
  input  logic [LAPW-1:0]  laps,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             wrap,
  output logic             done
);

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [LAPW-1:0]  lap_q, lap_d;
  logic             fin_q, fin_d;
  logic             busy_q, busy_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_count;
  logic             step_wrap;

  mod_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .count     (count_q),
    .mod_r     (mod_q),
    .up        (up),
    .count_next(step_count),
    .wrap_next (step_wrap)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mod_d   = mod_q;
    lap_d   = lap_q;
    fin_d   = fin_q;
    wrap_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mod_d   = modulus;
          lap_d   = laps;
          fin_d   = 1'b0;
          count_d = ((modulus == '0) || (load_val < modulus)) ? load_val : '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // fin_q marks the cycle showing the final wrap; the run is over, so
        // stop/en no longer matter and done follows on the next edge.
        if (fin_q) begin
          fin_d   = 1'b0;
          state_d = DONE;
        end else if (stop) begin
          state_d = IDLE;
        end else if (en) begin
          count_d = step_count;
          wrap_d  = step_wrap;
          if (step_wrap && (lap_q != '0)) begin
            lap_d = lap_q - LAPW'(1);
            if (lap_q == LAPW'(1)) begin
              fin_d = 1'b1;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      mod_q   <= '0;
      lap_q   <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mod_q   <= mod_d;
      lap_q   <= lap_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign wrap  = wrap_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Scoreboard bench: a behavioural run model predicts each cycle's outputs,
// a negedge monitor pops and compares them against the counter.
module tb_mod_counter_ctrl;

  localparam int W = 8;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         en;
  logic         up;
  logic [W-1:0] modulus;
  logic [W-1:0] load_val;
  logic [L-1:0] laps;
  logic [W-1:0] count;
  logic         busy;
  logic         wrap;
  logic         done;

  mod_counter_ctrl #(
    .WIDTH(W),
    .LAPW (L)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .en      (en),
    .up      (up),
    .modulus (modulus),
    .load_val(load_val),
    .laps    (laps),
    .count   (count),
    .busy    (busy),
    .wrap    (wrap),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit bsy;
    bit wrp;
    bit dn;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model: a run is "active" with a value cnt in [0, period);
  // after the last lap's wrap there is a two-cycle tail (wrap shown, then done).
  int m_cnt      = 0;
  int m_period   = 1;
  int m_laps     = 0;
  bit m_free     = 1'b0;
  bit m_active   = 1'b0;
  int m_tail     = 0;
  bit m_wrap     = 1'b0;

  function automatic void model_step();
    m_wrap = 1'b0;
    if (reset) begin
      m_cnt    = 0;
      m_active = 1'b0;
      m_tail   = 0;
      m_laps   = 0;
      m_period = 1;
    end else if (m_tail == 2) begin
      m_tail = 1;
    end else if (m_tail == 1) begin
      m_tail   = 0;
      m_active = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_period = (modulus == 0) ? (1 << W) : int'(modulus);
        m_cnt    = ((modulus == 0) || (load_val < modulus)) ? int'(load_val) : 0;
        m_laps   = int'(laps);
        m_free   = (laps == 0);
        m_active = 1'b1;
      end
    end else if (stop) begin
      m_active = 1'b0;
    end else if (en) begin
      if (up) begin
        m_cnt  = (m_cnt + 1) % m_period;
        m_wrap = (m_cnt == 0);
      end else begin
        m_wrap = (m_cnt == 0);
        m_cnt  = (m_cnt + m_period - 1) % m_period;
      end
      if (m_wrap && !m_free) begin
        m_laps = m_laps - 1;
        if (m_laps == 0) m_tail = 2;
      end
    end
  endfunction

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_step();
    cyc   = cyc + 1;
    e.cnt = m_cnt;
    e.bsy = m_active;
    e.wrp = m_wrap;
    e.dn  = (m_tail == 1);
    e.cyc = cyc;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req, input int c);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, c, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("count", int'(count), e.cnt, e.cyc);
      check("busy",  int'(busy),  int'(e.bsy), e.cyc);
      check("wrap",  int'(wrap),  int'(e.wrp), e.cyc);
      check("done",  int'(done),  int'(e.dn),  e.cyc);
    end
  end

  task automatic idle_inputs();
    reset = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0; up = 1'b1;
  endtask

  task automatic begin_run(input int m, input int ld, input int lp, input bit u);
    modulus  = W'(m);
    load_val = W'(ld);
    laps     = L'(lp);
    up       = u;
    en       = 1'b1;
    start    = 1'b1;
    cycle();
    start    = 1'b0;
  endtask

  initial begin
    idle_inputs();
    modulus = '0; load_val = '0; laps = '0;

    // Reset, then a one-lap up run from 3 with period 5.
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    begin_run(5, 3, 1, 1'b1);
    repeat (6) cycle();

    // Down count over the full 8-bit range, two laps.
    begin_run(0, 1, 2, 1'b0);
    repeat (262) cycle();

    // Out-of-range load, then en gating 1,0,1.
    begin_run(4, 9, 0, 1'b1);
    en = 1'b1; cycle();
    en = 1'b0; cycle();
    en = 1'b1; cycle();
    stop = 1'b1; cycle();
    stop = 1'b0; cycle();

    // Stop on the edge where 3 would wrap to 0.
    begin_run(4, 1, 1, 1'b1);
    cycle(); cycle();
    stop = 1'b1; cycle();
    stop = 1'b0; en = 1'b0;
    repeat (3) cycle();

    // Free-run period 3 with a start pulse mid-run.
    begin_run(3, 0, 0, 1'b1);
    repeat (4) cycle();
    start = 1'b1; load_val = W'(2); cycle();
    start = 1'b0;
    repeat (5) cycle();
    stop = 1'b1; cycle();
    stop = 1'b0; cycle();

    // Reset while count is 2, then a normal restart.
    begin_run(8, 0, 3, 1'b1);
    cycle(); cycle();
    reset = 1'b1; cycle();
    reset = 1'b0;
    cycle();
    begin_run(6, 4, 1, 1'b1);
    repeat (6) cycle();

    // Back-to-back: hold start high across done.
    modulus = W'(2); load_val = W'(0); laps = L'(1); up = 1'b1; en = 1'b1;
    start = 1'b1;
    repeat (10) cycle();
    start = 1'b0;
    repeat (3) cycle();

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      int r;
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      en    = ($urandom_range(0, 3) != 0);
      up    = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 5));
      case (r)
        0:       modulus = W'(0);
        1:       modulus = W'(1);
        2:       modulus = W'(2);
        3:       modulus = W'($urandom_range(3, 9));
        default: modulus = W'($urandom_range(0, 255));
      endcase
      load_val = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 9))
                                             : W'($urandom_range(0, 255));
      laps = L'($urandom_range(0, 3));
      cycle();
    end

    idle_inputs();
    cycle();
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0, cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
